// File: rtl/fft_1024_bitrev_reader.sv
// Ping-pong reorder buffer: bit-reversed FFT output stream in, natural-order frames out.
// Define FFT_REORDER_FRAME_ERR_EN to add the saturating aborted-frame counter err_count.
module fft_1024_bitrev_reader #(
  parameter int LOG2N = 10,
  parameter int WIDTH = 16
) (
  input  logic                    clock_c,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    in_sync,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic                    out_sync,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im
`ifdef FFT_REORDER_FRAME_ERR_EN
  ,
  output logic [7:0]              err_count
`endif
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] IDX_ZERO = '0;
  localparam logic [LOG2N-1:0] IDX_ONE  = LOG2N'(1);
  localparam logic [LOG2N-1:0] IDX_LAST = '1;

  typedef enum logic {WR_WAIT, WR_FILL} wr_state_t;
  typedef enum logic {RD_IDLE, RD_READ} rd_state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = v[LOG2N-1-b];
    return r;
  endfunction

  logic [2*WIDTH-1:0] mem_q [2*N];

  wr_state_t          wr_state_q, wr_state_d;
  logic [LOG2N-1:0]   wi_q, wi_d;
  logic               wbank_q, wbank_d;
  logic               wr_en, wr_done, resync;
  logic [LOG2N-1:0]   wr_idx, wr_addr;

  rd_state_t          rd_state_q, rd_state_d;
  logic [LOG2N-1:0]   ri_q, ri_d;
  logic               rd_fire;

  logic               vld_p1_q, sync_p1_q;
  logic [2*WIDTH-1:0] rdata_p1_q;
  logic               out_valid_q, out_sync_q;
  logic signed [WIDTH-1:0] out_re_q, out_im_q;

  // An in_sync anywhere but slot 0 of a filling frame restarts that frame in place.
  assign resync  = (wr_state_q == WR_FILL) && in_sync && (wi_q != IDX_ZERO);
  assign wr_addr = bitrev(wr_idx);
  assign rd_fire = (rd_state_q == RD_READ);

  always_comb begin
    wr_state_d = wr_state_q;
    wi_d       = wi_q;
    wbank_d    = wbank_q;
    wr_en      = 1'b0;
    wr_idx     = wi_q;
    wr_done    = 1'b0;
    rd_state_d = rd_state_q;
    ri_d       = ri_q;

    case (wr_state_q)
      WR_WAIT: begin
        if (in_sync) begin
          wr_en      = 1'b1;
          wr_idx     = IDX_ZERO;
          wi_d       = IDX_ONE;
          wr_state_d = WR_FILL;
        end
      end
      default: begin
        wr_en = 1'b1;
        if (resync) begin
          wr_idx = IDX_ZERO;
          wi_d   = IDX_ONE;
        end else begin
          wi_d = wi_q + IDX_ONE;
          if (wi_q == IDX_LAST) begin
            wr_done = 1'b1;
            wbank_d = ~wbank_q;
          end
        end
      end
    endcase

    case (rd_state_q)
      RD_IDLE: begin
        if (wr_done) begin
          rd_state_d = RD_READ;
          ri_d       = IDX_ZERO;
        end
      end
      default: begin
        ri_d = ri_q + IDX_ONE;
        if (ri_q == IDX_LAST && !wr_done) rd_state_d = RD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_c or negedge reset_n) begin
    if (!reset_n) begin
      wr_state_q  <= WR_WAIT;
      wi_q        <= IDX_ZERO;
      wbank_q     <= 1'b0;
      rd_state_q  <= RD_IDLE;
      ri_q        <= IDX_ZERO;
      vld_p1_q    <= 1'b0;
      sync_p1_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sync_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else if (enable) begin
      wr_state_q  <= wr_state_d;
      wi_q        <= wi_d;
      wbank_q     <= wbank_d;
      rd_state_q  <= rd_state_d;
      ri_q        <= ri_d;
      // p1: memory word for ri fetched; p2: presented on the outputs
      vld_p1_q    <= rd_fire;
      sync_p1_q   <= rd_fire && (ri_q == IDX_ZERO);
      out_valid_q <= vld_p1_q;
      out_sync_q  <= sync_p1_q;
      if (vld_p1_q) begin
        out_re_q <= rdata_p1_q[2*WIDTH-1:WIDTH];
        out_im_q <= rdata_p1_q[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clock_c) begin
    if (enable && wr_en) mem_q[{wbank_q, wr_addr}] <= {in_re, in_im};
  end

  always_ff @(posedge clock_c) begin
    if (enable && rd_fire) rdata_p1_q <= mem_q[{~wbank_q, ri_q}];
  end

  assign out_valid = out_valid_q;
  assign out_sync  = out_sync_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

`ifdef FFT_REORDER_FRAME_ERR_EN
  logic [7:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (resync && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clock_c or negedge reset_n) begin
    if (!reset_n)    err_q <= '0;
    else if (enable) err_q <= err_d;
  end

  assign err_count = err_q;
`endif

  // A write takes at least N cycles, so completion only lands when the reader can take it.
  assert property (@(posedge clock_c) disable iff (!reset_n)
    (enable && wr_done) |-> (rd_state_q == RD_IDLE || ri_q == IDX_LAST));

endmodule

// File: tb/tb_fft_1024_bitrev_reader.sv
// Directed self-checking bench for fft_1024_bitrev_reader (default and err-count builds).
module tb_fft_1024_bitrev_reader;
  localparam int W = 16;

  logic clock_c = 1'b0;
  logic reset_n = 1'b1;
  logic enable  = 1'b1;
  logic in_sync = 1'b0;
  logic signed [W-1:0] in_re = '0;
  logic signed [W-1:0] in_im = '0;
  logic out_sync, out_valid;
  logic signed [W-1:0] out_re, out_im;
`ifdef FFT_REORDER_FRAME_ERR_EN
  logic [7:0] err_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [33:0] got, exp_v;

  always #5 clock_c = ~clock_c;

  fft_1024_bitrev_reader #(.LOG2N(10), .WIDTH(W)) dut (
    .clock_c   (clock_c),
    .reset_n   (reset_n),
    .enable    (enable),
    .in_sync   (in_sync),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_sync  (out_sync),
    .out_valid (out_valid),
    .out_re    (out_re),
    .out_im    (out_im)
`ifdef FFT_REORDER_FRAME_ERR_EN
    ,
    .err_count (err_count)
`endif
  );

  task automatic tick();
    @(posedge clock_c);
    #1;
  endtask

  task automatic drive(input logic s, input int val);
    in_sync = s;
    in_re   = W'(val);
    in_im   = W'(-val);
  endtask

  function automatic logic [9:0] brev(input logic [9:0] v);
    logic [9:0] r;
    r = {<<{v}};
    return r;
  endfunction

  // Expected {valid, sync, re, im}; im is always the negated re in these streams.
  function automatic logic [33:0] expv(input logic v, input logic s, input int val);
    logic [15:0] re, im;
    re = 16'(val);
    im = 16'(-val);
    return {v, s, re, im};
  endfunction

  task automatic do_reset();
    enable = 1'b1;
    drive(1'b0, 0);
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #2;
    got = {out_valid, out_sync, out_re, out_im};
    n_cmp++;
    if (got !== 34'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h expected=%h", got, 34'd0);
    end
`ifdef FFT_REORDER_FRAME_ERR_EN
    n_cmp++;
    if (err_count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_err got=%0d expected=0", err_count);
    end
`endif
    do_reset();
  endtask

  task automatic test_ramp();
    do_reset();
    for (int t = 0; t <= 2048; t++) begin
      drive(t == 0, (t < 1024) ? t : 0);
      tick();
      if (t < 1025) exp_v = expv(1'b0, 1'b0, 0);
      else          exp_v = expv(1'b1, t == 1025, int'(brev(10'(t - 1025))));
      got = {out_valid, out_sync, out_re, out_im};
      n_cmp++;
      if (exp_v[33] ? (got !== exp_v) : (got[33:32] !== exp_v[33:32])) begin
        n_bad++;
        $display("FAIL ramp t=%0d got=%h expected=%h", t, got, exp_v);
      end
      if (t == 1025 + 512) begin
        n_cmp++;
        if (out_re !== 16'sd1) begin
          n_bad++;
          $display("FAIL ramp_idx512 got=%0d expected=1", out_re);
        end
      end
      if (t == 1026) begin
        n_cmp++;
        if (out_re !== 16'sd512 || out_im !== -16'sd512) begin
          n_bad++;
          $display("FAIL ramp_idx1 got=%0d/%0d expected=512/-512", out_re, out_im);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int j, f;
    do_reset();
    for (int t = 0; t <= 4096; t++) begin
      drive(t == 0, (t < 3072) ? t : 0);
      tick();
      if (t < 1025) begin
        exp_v = expv(1'b0, 1'b0, 0);
      end else begin
        j = (t - 1025) % 1024;
        f = (t - 1025) / 1024;
        exp_v = expv(1'b1, j == 0, f * 1024 + int'(brev(10'(j))));
      end
      got = {out_valid, out_sync, out_re, out_im};
      n_cmp++;
      if (exp_v[33] ? (got !== exp_v) : (got[33:32] !== exp_v[33:32])) begin
        n_bad++;
        $display("FAIL back_to_back t=%0d got=%h expected=%h", t, got, exp_v);
      end
    end
  endtask

  task automatic test_enable_gating();
    int e, cyc;
    logic en;
    do_reset();
    e = -1;
    cyc = 0;
    while (e < 2048 && cyc < 12000) begin
      en = 1'($urandom_range(0, 1));
      enable = en;
      if (en) drive(e + 1 == 0, (e + 1 < 1024) ? e + 1 : 0);
      else    drive(1'b1, 999);
      tick();
      cyc++;
      if (en) e++;
      if (e < 1025) exp_v = expv(1'b0, 1'b0, 0);
      else          exp_v = expv(1'b1, e == 1025, int'(brev(10'(e - 1025))));
      got = {out_valid, out_sync, out_re, out_im};
      n_cmp++;
      if (exp_v[33] ? (got !== exp_v) : (got[33:32] !== exp_v[33:32])) begin
        n_bad++;
        $display("FAIL enable_gating cyc=%0d en=%0b got=%h expected=%h", cyc, en, got, exp_v);
      end
    end
    n_cmp++;
    if (e < 2048) begin
      n_bad++;
      $display("FAIL enable_gating_budget enabled_edges=%0d expected=2048", e);
    end
    enable = 1'b1;
  endtask

  task automatic test_resync();
    int val;
    do_reset();
    for (int t = 0; t <= 3372; t++) begin
      if (t < 1324)       val = t;
      else if (t <= 2347) val = 2048 + t - 1324;
      else                val = 0;
      drive(t == 0 || t == 1324, val);
      tick();
      if (t >= 1025 && t <= 2048)
        exp_v = expv(1'b1, t == 1025, int'(brev(10'(t - 1025))));
      else if (t >= 2349)
        exp_v = expv(1'b1, t == 2349, 2048 + int'(brev(10'(t - 2349))));
      else
        exp_v = expv(1'b0, 1'b0, 0);
      got = {out_valid, out_sync, out_re, out_im};
      n_cmp++;
      if (exp_v[33] ? (got !== exp_v) : (got[33:32] !== exp_v[33:32])) begin
        n_bad++;
        $display("FAIL resync t=%0d got=%h expected=%h", t, got, exp_v);
      end
    end
`ifdef FFT_REORDER_FRAME_ERR_EN
    n_cmp++;
    if (err_count !== 8'd1) begin
      n_bad++;
      $display("FAIL resync_err got=%0d expected=1", err_count);
    end
`endif
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    for (int t = 0; t <= 1523; t++) begin
      drive(t == 0, (t < 1024) ? t : 0);
      tick();
    end
    exp_v = expv(1'b1, 1'b0, int'(brev(10'd498)));
    got = {out_valid, out_sync, out_re, out_im};
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL mid_read_before got=%h expected=%h", got, exp_v);
    end
    #1 reset_n = 1'b0;
    #1;
    got = {out_valid, out_sync, out_re, out_im};
    n_cmp++;
    if (got !== 34'd0) begin
      n_bad++;
      $display("FAIL mid_read_async_clear got=%h expected=%h", got, 34'd0);
    end
    tick();
    tick();
    reset_n = 1'b1;
    for (int t = 0; t < 1200; t++) begin
      drive(1'b0, 777);
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || out_sync !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_read_quiet t=%0d got=%0b%0b expected=00", t, out_valid, out_sync);
      end
    end
    for (int t = 0; t <= 1026; t++) begin
      drive(t == 0, (t < 1024) ? t + 100 : 0);
      tick();
      if (t < 1025)       exp_v = expv(1'b0, 1'b0, 0);
      else if (t == 1025) exp_v = expv(1'b1, 1'b1, 100);
      else                exp_v = expv(1'b1, 1'b0, 612);
      got = {out_valid, out_sync, out_re, out_im};
      n_cmp++;
      if (exp_v[33] ? (got !== exp_v) : (got[33:32] !== exp_v[33:32])) begin
        n_bad++;
        $display("FAIL mid_read_restart t=%0d got=%h expected=%h", t, got, exp_v);
      end
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int t = 0; t < 5000; t++) begin
      drive(1'b0, int'($urandom_range(0, 65535)));
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || out_sync !== 1'b0) begin
        n_bad++;
        $display("FAIL idle t=%0d got=%0b%0b expected=00", t, out_valid, out_sync);
      end
    end
`ifdef FFT_REORDER_FRAME_ERR_EN
    n_cmp++;
    if (err_count !== 8'd0) begin
      n_bad++;
      $display("FAIL idle_err got=%0d expected=0", err_count);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp();
    test_back_to_back();
    test_enable_gating();
    test_resync();
    test_reset_mid_read();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
